// File: rtl/lcd_cmd_seq.sv
// rtl/lcd_cmd_seq.sv - LCD command-list sequencer with busy/done handshake and watchdog
module lcd_cmd_seq #(
  parameter int DEPTH_W = 4,
  parameter int TO_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [DEPTH_W-1:0] prog_addr,
  input  logic [2:0]         prog_data,
  input  logic [DEPTH_W:0]   seq_len,
  input  logic               start,
  input  logic               lcd_busy,
  input  logic               lcd_done,
  output logic [2:0]         cmd,
  output logic               cmd_valid,
  output logic               seq_busy,
  output logic               seq_done,
  output logic [DEPTH_W:0]   cmd_cnt,
  output logic               timeout_err
);
  typedef enum logic [2:0] {IDLE, READY, ISSUE, ACK, WAIT, FIN} state_t;

  localparam logic [DEPTH_W:0] MAX_LEN = {1'b1, {DEPTH_W{1'b0}}};
  localparam logic [TO_W-1:0]  WD_MAX  = {TO_W{1'b1}};

  state_t            state, state_n;
  logic [2:0]        list [2**DEPTH_W];
  logic [DEPTH_W:0]  idx, idx_n, len, len_n, cnt_n;
  logic [TO_W-1:0]   wd, wd_n;
  logic              terr_n, stalled;

  always_ff @(posedge clk) begin
    if (prog_we && state == IDLE) list[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      len         <= '0;
      wd          <= '0;
      cmd_cnt     <= '0;
      timeout_err <= 1'b0;
      cmd         <= 3'd0;
      cmd_valid   <= 1'b0;
      seq_busy    <= 1'b0;
      seq_done    <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      len         <= len_n;
      wd          <= wd_n;
      cmd_cnt     <= cnt_n;
      timeout_err <= terr_n;
      // cmd doubles as the latched opcode that WAIT decides on
      cmd_valid   <= (state == ISSUE);
      if (state == ISSUE) cmd <= list[idx[DEPTH_W-1:0]];
      seq_done    <= (state == FIN);
      seq_busy    <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    len_n   = len;
    cnt_n   = cmd_cnt;
    terr_n  = timeout_err;
    wd_n    = '0;
    stalled = 1'b0;
    case (state)
      IDLE: if (start) begin
        len_n   = (seq_len > MAX_LEN) ? MAX_LEN : seq_len;
        idx_n   = '0;
        cnt_n   = '0;
        terr_n  = 1'b0;
        state_n = (seq_len == '0) ? FIN : READY;
      end
      READY: if (!lcd_busy) state_n = ISSUE; else stalled = 1'b1;
      ISSUE: state_n = ACK;
      ACK:   if (lcd_busy) state_n = WAIT; else stalled = 1'b1;
      WAIT: begin
        if ((cmd == 3'd0) ? lcd_done : !lcd_busy) begin
          cnt_n   = cmd_cnt + 1'b1;
          idx_n   = idx + 1'b1;
          state_n = (cmd == 3'd0 || (idx + 1'b1) == len) ? FIN : ISSUE;
        end else begin
          stalled = 1'b1;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (stalled) begin
      wd_n = wd + 1'b1;
      if (wd_n == WD_MAX) begin
        terr_n  = 1'b1;
        state_n = FIN;
        wd_n    = '0;
      end
    end
  end
endmodule

// File: tb/tb_lcd_cmd_seq.sv
// tb/tb_lcd_cmd_seq.sv - scoreboard bench for lcd_cmd_seq with a behavioural LCD model
module tb_lcd_cmd_seq;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [2:0] prog_data = '0;
  logic [4:0] seq_len = '0;
  logic       start = 1'b0;
  logic       lcd_busy = 1'b0;
  logic       lcd_done = 1'b0;
  logic [2:0] cmd;
  logic       cmd_valid, seq_busy, seq_done, timeout_err;
  logic [4:0] cmd_cnt;

  lcd_cmd_seq #(.DEPTH_W(4), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .seq_len(seq_len), .start(start),
    .lcd_busy(lcd_busy), .lcd_done(lcd_done), .cmd(cmd), .cmd_valid(cmd_valid),
    .seq_busy(seq_busy), .seq_done(seq_done), .cmd_cnt(cmd_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // LCD model: busy while loading an image, then busy for 6 cycles per command; write ends with done
  int   load_until = 0;
  bit   stall_en = 0;
  int   stall_op = 0;
  int   work_left = 0;
  bit   pend_write = 0;
  always @(negedge clk) begin
    lcd_done = 1'b0;
    if (cmd_valid && !(stall_en && int'(cmd) == stall_op)) begin
      work_left  = 6;
      pend_write = (cmd == 3'd0);
    end else if (work_left > 0) begin
      work_left--;
      if (work_left == 0 && pend_write) lcd_done = 1'b1;
    end
    lcd_busy = (cyc < load_until) || (work_left > 0);
  end

  int n_run = 0, n_fail = 0;
  int n_valid = 0, n_done = 0;
  int t_start = 0, t_valid = 0, t_done = 0;
  bit prev_valid = 0;
  int exp_cmd[$];
  int exp_cnt[$];
  int exp_terr[$];

  task automatic chk(input string name, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (cmd_valid) begin
        n_valid++;
        t_valid = cyc;
        chk("valid_single_cycle", int'(prev_valid), 0);
        chk("valid_during_load", int'(cyc < load_until), 0);
        if (exp_cmd.size() == 0) begin
          n_run++; n_fail++;
          $display("FAIL cmd_unexpected: got %0d expected none", cmd);
        end else chk("cmd", cmd, exp_cmd.pop_front());
      end
      prev_valid = cmd_valid;
      if (seq_done) begin
        n_done++;
        t_done = cyc;
        if (exp_cnt.size() == 0) begin
          n_run++; n_fail++;
          $display("FAIL done_unexpected: got seq_done expected none");
        end else begin
          chk("cmd_cnt", cmd_cnt, exp_cnt.pop_front());
          chk("timeout_err", timeout_err, exp_terr.pop_front());
        end
      end
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic prog(input int a, input int d);
    prog_we = 1'b1; prog_addr = 4'(a); prog_data = 3'(d);
    tick(1);
    prog_we = 1'b0;
  endtask

  task automatic expect_end(input int cnt, input int terr);
    exp_cnt.push_back(cnt);
    exp_terr.push_back(terr);
  endtask

  task automatic kick(input int len);
    seq_len = 5'(len); start = 1'b1; t_start = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, input int budget);
    for (int i = 0; i < budget && n_done == n0; i++) tick(1);
    chk("seq_done_seen", int'(n_done != n0), 1);
    tick(2);
  endtask

  task automatic wait_valid(input int target, input int budget);
    for (int i = 0; i < budget && n_valid < target; i++) tick(1);
    chk("cmd_valid_seen", int'(n_valid >= target), 1);
  endtask

  int n0, v0;
  int l1[4] = '{1, 3, 5, 0};
  int l5[4] = '{1, 2, 4, 1};
  int l6[4] = '{1, 2, 3, 5};

  initial begin
    fork monitor(); join_none
    tick(3);
    chk("rst_cmd", cmd, 0);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_busy", seq_busy, 0);
    chk("rst_cnt", cmd_cnt, 0);
    reset = 1'b0;
    tick(2);

    // list [1,3,5,0] started while the LCD is still loading an image
    for (int i = 0; i < 4; i++) begin prog(i, l1[i]); exp_cmd.push_back(l1[i]); end
    expect_end(4, 0);
    load_until = cyc + 65;
    n0 = n_done; kick(4);
    chk("busy_after_start", seq_busy, 1);
    wait_done(n0, 400);

    // write mid-list stops the sequence
    prog(0, 6); prog(1, 0); prog(2, 2);
    exp_cmd.push_back(6); exp_cmd.push_back(0);
    expect_end(2, 0);
    n0 = n_done; kick(3); wait_done(n0, 200);

    // empty sequence
    v0 = n_valid;
    expect_end(0, 0);
    n0 = n_done; kick(0); wait_done(n0, 20);
    chk("len0_done_delay", t_done - t_start, 2);
    chk("len0_no_valid", n_valid - v0, 0);

    // length clamp to 16
    for (int i = 0; i < 16; i++) begin prog(i, (i % 7) + 1); exp_cmd.push_back((i % 7) + 1); end
    expect_end(16, 0);
    n0 = n_done; kick(20); wait_done(n0, 600);

    // LCD never acknowledges opcode 4
    for (int i = 0; i < 4; i++) prog(i, l5[i]);
    exp_cmd.push_back(1); exp_cmd.push_back(2); exp_cmd.push_back(4);
    expect_end(2, 1);
    stall_en = 1; stall_op = 4;
    n0 = n_done; kick(4); wait_done(n0, 700);
    chk("timeout_delay", t_done - t_valid, 256);
    chk("timeout_sticky", timeout_err, 1);
    stall_en = 0;
    exp_cmd.push_back(1);
    expect_end(1, 0);
    n0 = n_done; kick(1);
    chk("timeout_cleared", timeout_err, 0);
    wait_done(n0, 100);

    // asynchronous reset during WAIT of command 2
    for (int i = 0; i < 4; i++) begin prog(i, l6[i]); exp_cmd.push_back(l6[i]); end
    expect_end(4, 0);
    v0 = n_valid; n0 = n_done; kick(4);
    wait_valid(v0 + 2, 100);
    tick(2);
    #2 reset = 1'b1;
    #1;
    chk("arst_cmd", cmd, 0);
    chk("arst_valid", cmd_valid, 0);
    chk("arst_busy", seq_busy, 0);
    chk("arst_done", seq_done, 0);
    chk("arst_cnt", cmd_cnt, 0);
    chk("arst_terr", timeout_err, 0);
    exp_cmd.delete(); exp_cnt.delete(); exp_terr.delete();
    tick(1);
    reset = 1'b0;
    tick(10);
    chk("arst_no_done", n_done - n0, 0);

    // prog_we and start while busy are ignored
    for (int i = 0; i < 4; i++) exp_cmd.push_back(l6[i]);
    expect_end(4, 0);
    v0 = n_valid; n0 = n_done; kick(4);
    wait_valid(v0 + 1, 100);
    chk("busy_when_ignored", seq_busy, 1);
    prog_we = 1'b1; prog_addr = 4'd1; prog_data = 3'd7; start = 1'b1; seq_len = 5'd1;
    tick(1);
    prog_we = 1'b0; start = 1'b0;
    wait_done(n0, 200);
    exp_cmd.push_back(1); exp_cmd.push_back(2);
    expect_end(2, 0);
    n0 = n_done; kick(2); wait_done(n0, 100);

    chk("cmd_queue_empty", exp_cmd.size(), 0);
    chk("end_queue_empty", exp_cnt.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/lcd_cmd_seq.md
Name: lcd_cmd_seq

Overview:
Command sequencer that drives the LCD image controller's cmd/cmd_valid/busy/done handshake from a small programmable command list.
- Lets a host or testbench load a script of 3-bit LCD opcodes (shift, average, mirror, write) once, then run it with a single start pulse.
- Issues one command at a time, waits for the LCD controller to accept and finish each, and stops after the list ends or a write command completes.
- Watchdog flags a stalled LCD controller.

Parameters:
DEPTH_W, 4, address width of command list (2^DEPTH_W entries, max 16 commands)
TO_W, 8, width of watchdog counter; timeout after 2^TO_W-1 consecutive wait cycles

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
prog_we  input  1  write enable for command list (honoured only in IDLE)
prog_addr  input  DEPTH_W  command list write address
prog_data  input  3  opcode to store (0 write, 1 up, 2 down, 3 left, 4 right, 5 avg, 6 mirror-x, 7 mirror-y)
seq_len  input  DEPTH_W+1  number of commands to run, sampled on accepted start
start  input  1  one-cycle pulse, begins sequence
lcd_busy  input  1  busy from LCD controller
lcd_done  input  1  done from LCD controller
cmd  output  3  opcode to LCD controller
cmd_valid  output  1  command strobe to LCD controller
seq_busy  output  1  high whenever FSM not IDLE
seq_done  output  1  one-cycle pulse at sequence end (normal or timeout)
cmd_cnt  output  DEPTH_W+1  commands completed in current/last sequence
timeout_err  output  1  sticky watchdog error, cleared on next accepted start

Behaviour:
- Reset (async): state IDLE; cmd=0, cmd_valid=0, seq_busy=0, seq_done=0, cmd_cnt=0, timeout_err=0, idx=0, watchdog=0. Command list contents are not reset; they must be programmed before use.
- Command list: registered array. Write on rising edge when prog_we=1 and state=IDLE. prog_we in any other state is ignored.
- States: IDLE, READY, ISSUE, ACK, WAIT, FIN.
- IDLE, start=1:
  - latch len = min(seq_len, 2^DEPTH_W); clear idx, cmd_cnt, timeout_err.
  - len=0 -> FIN; else -> READY.
  - start outside IDLE is ignored.
- READY: wait for lcd_busy=0 (LCD still loading image), then -> ISSUE.
- ISSUE: exactly one cycle. cmd_valid=1, cmd=list[idx]; latch the opcode. -> ACK.
- ACK: wait for lcd_busy=1 (LCD registers busy one cycle after cmd_valid), then -> WAIT.
- WAIT:
  - latched opcode = 0 (write): wait for lcd_done=1.
  - any other opcode: wait for lcd_busy=0.
  - On completion: cmd_cnt++, idx++.
  - Go to FIN if the opcode was write (LCD returns to image load) or idx+1 = len; else -> ISSUE directly (LCD already idle).
- FIN: seq_done=1 for one cycle -> IDLE.
- cmd_valid is 0 in every state except ISSUE. cmd holds its last issued value outside ISSUE.
- Watchdog:
  - Counts cycles in READY, ACK, WAIT; clears on every state change.
  - At 2^TO_W-1: set timeout_err, -> FIN (seq_done pulses). Remaining commands are not issued, and cmd_cnt is not incremented for the stalled command.
- A write command in the middle of the list ends the sequence; later entries are never issued.
- Simultaneous lcd_busy=0 and lcd_done=1 in WAIT for write: completion is taken from lcd_done only.
- Reset mid-sequence: immediate return to IDLE with all outputs at reset values. No partial cmd_valid glitch, since outputs are registered.
- cmd_cnt saturates at len; it never wraps, because len <= 2^DEPTH_W and the width is DEPTH_W+1.

Test Plan:
- Program [1,3,5,0], seq_len=4, start while LCD model busy loading 65 cycles.
  -> no cmd_valid until lcd_busy=0; four single-cycle cmd_valid pulses with cmd 1,3,5,0; seq_done once after lcd_done; cmd_cnt=4; timeout_err=0.
- Program [6,0,2], seq_len=3.
  -> commands 6 and 0 issued, 2 never issued; cmd_cnt=2; seq_done pulses after lcd_done.
- seq_len=0, start.
  -> no cmd_valid; seq_done exactly 2 cycles after start; cmd_cnt=0.
- seq_len=20 with DEPTH_W=4.
  -> clamped to 16; 16 commands issued (no write in list); cmd_cnt=16.
- LCD model never raises lcd_busy after cmd 4.
  -> timeout_err=1 and seq_done after 255 ACK cycles; cmd_cnt unchanged; next start clears timeout_err.
- Assert reset during WAIT of command 2, and assert prog_we/start while seq_busy=1 in another run.
  -> all outputs return to 0 asynchronously; list writes and start are ignored while seq_busy=1, and the list is unchanged afterwards.
